// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// fifo_rd_pkg : shared types and helpers for the multi-channel FIFO read
//               controller (fifo_rd_arb_ctrl) and its round-robin picker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  typedef enum logic [1:0] {
    READY         = 2'd0,
    GET_FIFO_DATA = 2'd1,
    WAIT_STATE    = 2'd2,
    TRANSFER      = 2'd3
  } rd_state_t;

  localparam int TO_CNT_W = 8;

  // Channel index width; a single channel still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb.sv
// ============================================================================
// rr_arb : combinational round-robin picker; searches last_grant+1, +2, ...
//          (mod NUM_CH) for the first requesting channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb
  import fifo_rd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  assign any_req = |req;

  generate
    if (NUM_CH == 1) begin : g_single
      logic unused_last;
      assign unused_last = ^last_grant;
      assign grant       = '0;
    end else begin : g_multi
      int              idx;
      logic [CH_W-1:0] idx_w;
      logic            found;

      always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
          idx   = (int'(last_grant) + k) % NUM_CH;
          idx_w = CH_W'(idx);
          if (!found && req[idx_w]) begin
            grant = idx_w;
            found = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fifo_rd_arb_ctrl.sv
// ============================================================================
// fifo_rd_arb_ctrl : round-robin read controller for NUM_CH event FIFOs that
//                    feeds a UART TX; optional timeout-exit counter enabled
//                    by defining FIFO_RD_TOCNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_arb_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT_W   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       fifo_empty,
  input  logic [NUM_CH-1:0]       write_fifo_n,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    tx_busy,
  output logic [NUM_CH-1:0]       read_fifo_n,
  output logic                    ld_tx_data,
  output logic [ch_w(NUM_CH)-1:0] tx_sel,
  output logic                    timeout_err
`ifdef FIFO_RD_TOCNT_EN
  ,
  output logic [TO_CNT_W-1:0]     to_count
`endif
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int WC_W = 3;

  rd_state_t          state;
  rd_state_t          next;
  logic [NUM_CH-1:0]  eligible;
  logic [CH_W-1:0]    last_grant;
  logic [CH_W-1:0]    arb_grant;
  logic               any_req;
  logic [WC_W-1:0]    wait_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic               wait_done;
  logic               to_full;

  // A channel being written this cycle is skipped to avoid read/write overlap.
  assign eligible  = ch_enable & ~fifo_empty & write_fifo_n;
  assign wait_done = (wait_cnt == WC_W'(WAIT_CYCLES - 1));
  assign to_full   = &to_cnt;

  rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  always_comb begin
    next = state;
    case (state)
      READY:         if (!tx_busy && any_req) next = GET_FIFO_DATA;
      GET_FIFO_DATA: next = WAIT_STATE;
      WAIT_STATE:    if (wait_done) next = TRANSFER;
      TRANSFER:      if (tx_busy || to_full) next = READY;
      default:       next = READY;
    endcase
  end

  // Outputs are decoded from next so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= READY;
      read_fifo_n <= '1;
      ld_tx_data  <= 1'b0;
      tx_sel      <= '0;
      timeout_err <= 1'b0;
      last_grant  <= CH_W'(NUM_CH - 1);
      wait_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      state       <= next;
      read_fifo_n <= '1;
      ld_tx_data  <= (next == TRANSFER);
      timeout_err <= (state == TRANSFER) && !tx_busy && to_full;
      wait_cnt    <= (state == WAIT_STATE) ? wait_cnt + WC_W'(1) : '0;
      to_cnt      <= (state == TRANSFER) ? to_cnt + TIMEOUT_W'(1) : '0;
      if (state == READY && next == GET_FIFO_DATA) begin
        read_fifo_n <= ~(NUM_CH'(1) << arb_grant);
        tx_sel      <= arb_grant;
        last_grant  <= arb_grant;
      end
    end
  end

`ifdef FIFO_RD_TOCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_count <= '0;
    end else if (timeout_err && (to_count != {TO_CNT_W{1'b1}})) begin
      to_count <= to_count + TO_CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_arb_ctrl.sv
// ============================================================================
// tb_fifo_rd_arb_ctrl : scoreboard bench for fifo_rd_arb_ctrl (4 channels,
//                       WAIT_CYCLES=1, TIMEOUT_W=6).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_arb_ctrl;

  localparam int NUM_CH      = 4;
  localparam int WAIT_CYCLES = 1;
  localparam int TIMEOUT_W   = 6;
  localparam int TO_LEN      = 1 << TIMEOUT_W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fifo_empty = 4'hF;
  logic [3:0]  write_fifo_n = 4'hF;
  logic [3:0]  ch_enable = 4'hF;
  logic        tx_busy = 1'b0;
  logic [3:0]  read_fifo_n;
  logic        ld_tx_data;
  logic [1:0]  tx_sel;
  logic        timeout_err;
`ifdef FIFO_RD_TOCNT_EN
  logic [7:0]  to_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];

  fifo_rd_arb_ctrl #(
    .NUM_CH      (NUM_CH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT_W   (TIMEOUT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .write_fifo_n (write_fifo_n),
    .ch_enable    (ch_enable),
    .tx_busy      (tx_busy),
    .read_fifo_n  (read_fifo_n),
    .ld_tx_data   (ld_tx_data),
    .tx_sel       (tx_sel),
    .timeout_err  (timeout_err)
`ifdef FIFO_RD_TOCNT_EN
    ,
    .to_count     (to_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobe_of(input int ch);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ch);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo_empty = 4'hF;
    write_fifo_n = 4'hF;
    ch_enable  = 4'hF;
    tx_busy    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One complete word: grant, strobe, wait, load, accepted by tx_busy.
  task automatic run_word(input int ch, input logic [3:0] empty,
                          input logic [3:0] wrn, input logic [3:0] en);
    fifo_empty   = empty;
    write_fifo_n = wrn;
    ch_enable    = en;
    exp_q.push_back(ch);
    step();
    chk("strobe", {28'd0, read_fifo_n}, {28'd0, strobe_of(ch)});
    chk("tx_sel", {30'd0, tx_sel}, ch);
    chk("ld_early", {31'd0, ld_tx_data}, 0);
    fifo_empty   = 4'hF;
    write_fifo_n = 4'hF;
    ch_enable    = 4'hF;
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      step();
      chk("wait_strobe", {28'd0, read_fifo_n}, 32'hF);
      chk("wait_ld", {31'd0, ld_tx_data}, 0);
    end
    step();
    chk("ld_rise", {31'd0, ld_tx_data}, 1);
    tx_busy = 1'b1;
    step();
    chk("busy_exit", {31'd0, ld_tx_data}, 0);
    chk("busy_noerr", {31'd0, timeout_err}, 0);
    tx_busy = 1'b0;
  endtask

  // Scoreboard: every strobe observed must match the next expected grant.
  always @(negedge clk) begin
    int c;
    if (read_fifo_n !== 4'hF) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", {28'd0, read_fifo_n}, 32'hF);
      end else begin
        c = exp_q.pop_front();
        chk("sb_strobe", {28'd0, read_fifo_n}, {28'd0, strobe_of(c)});
        chk("sb_tx_sel", {30'd0, tx_sel}, c);
      end
    end
  end

  initial begin
    int n;

    do_reset();
    chk("rst_read_n", {28'd0, read_fifo_n}, 32'hF);
    chk("rst_ld", {31'd0, ld_tx_data}, 0);
    chk("rst_tx_sel", {30'd0, tx_sel}, 0);
    chk("rst_toerr", {31'd0, timeout_err}, 0);
`ifdef FIFO_RD_TOCNT_EN
    chk("rst_to_count", {24'd0, to_count}, 0);
`endif

    // Single channel 2.
    run_word(2, 4'b1011, 4'hF, 4'hF);

    // All channels non-empty: rotation from reset.
    do_reset();
    for (int k = 0; k < 5; k++) run_word(k % 4, 4'b0000, 4'hF, 4'hF);

    // Timeout with tx_busy held low.
    do_reset();
    fifo_empty = 4'b1110;
    exp_q.push_back(0);
    for (int i = 0; i < 20 && !ld_tx_data; i++) step();
    chk("to_ld_seen", {31'd0, ld_tx_data}, 1);
    fifo_empty = 4'hF;
    n = 0;
    while (ld_tx_data && n < 200) begin
      n++;
      step();
    end
    chk("to_len", n, TO_LEN);
    chk("to_err_pulse", {31'd0, timeout_err}, 1);
    step();
    chk("to_err_once", {31'd0, timeout_err}, 0);
`ifdef FIFO_RD_TOCNT_EN
    chk("to_count", {24'd0, to_count}, 1);
`endif

    // Ineligible channel 1 skipped in favour of 3.
    do_reset();
    run_word(0, 4'b1110, 4'hF, 4'hF);
    run_word(3, 4'b0101, 4'b1101, 4'hF);
    run_word(3, 4'b0101, 4'hF, 4'b1101);

    // Reset during WAIT_STATE.
    do_reset();
    fifo_empty = 4'b1011;
    exp_q.push_back(2);
    step();
    fifo_empty = 4'hF;
    step();
    chk("mid_wait_ld", {31'd0, ld_tx_data}, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_read_n", {28'd0, read_fifo_n}, 32'hF);
    chk("mid_rst_ld", {31'd0, ld_tx_data}, 0);
    chk("mid_rst_tx_sel", {30'd0, tx_sel}, 0);
    reset = 1'b0;
    step();
    step();
    chk("post_rst_ld", {31'd0, ld_tx_data}, 0);

    // tx_busy coincides with the all-ones timeout count.
    do_reset();
    fifo_empty = 4'b1110;
    exp_q.push_back(0);
    for (int i = 0; i < 20 && !ld_tx_data; i++) step();
    chk("co_ld_seen", {31'd0, ld_tx_data}, 1);
    fifo_empty = 4'hF;
    for (int i = 0; i < TO_LEN - 1; i++) step();
    chk("co_ld_hold", {31'd0, ld_tx_data}, 1);
    tx_busy = 1'b1;
    step();
    chk("co_exit", {31'd0, ld_tx_data}, 0);
    chk("co_noerr", {31'd0, timeout_err}, 0);
    tx_busy = 1'b0;
    step();
    chk("co_noerr2", {31'd0, timeout_err}, 0);

    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
